// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative multiply/divide unit with architectural HI/LO registers.
//
// Runs MULT/MULTU (shift-add) and DIV/DIVU (restoring) one bit per cycle on
// unsigned magnitudes, then fixes up the signs in a final cycle before writing
// HI/LO. MTHI/MTLO write HI/LO directly in a single cycle.
//
// State  | meaning
// IDLE   | waiting for start_i; MTHI/MTLO handled here
// CALC   | WIDTH iterations, counter 0..WIDTH-1
// FIX    | sign correction and HI/LO write-back, done_o raised
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   start_i  request, accepted only in IDLE
//   op_i     000/111 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO
//   src0_i   multiplicand / dividend / MTHI-MTLO data
//   src1_i   multiplier / divisor
//   flush_i  abort an in-flight operation
//   hi_o     HI register
//   lo_o     LO register
//   busy_o   operation in flight (CALC or FIX)
//   done_o   one-cycle pulse after mul/div write-back
//   div0_o   with done_o: last op was a divide by zero
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] src0_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div0_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  // acc holds {partial product} for multiply, {remainder, dividend/quotient} for divide
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               div_zero;

  logic               op_mul;
  logic               op_div;
  logic               op_signed;
  logic [WIDTH-1:0]   mag0;
  logic [WIDTH-1:0]   mag1;

  assign op_mul    = (op_i == OP_MULT) || (op_i == OP_MULTU);
  assign op_div    = (op_i == OP_DIV)  || (op_i == OP_DIVU);
  assign op_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign mag0      = (op_signed && src0_i[WIDTH-1]) ? -src0_i : src0_i;
  assign mag1      = (op_signed && src1_i[WIDTH-1]) ? -src1_i : src1_i;

  // multiply step: conditionally add multiplicand into the upper half, carry kept
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);

  // restoring divide step: shift next dividend bit into the remainder, try subtract
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             div_fit;
  logic [WIDTH-1:0] rem_new;
  assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, opb};
  assign div_fit  = (rem_sh >= {1'b0, opb});
  assign rem_new  = div_fit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];

  // sign fix-up; MIN/-1 and MIN*MIN fall out naturally from two's-complement wrap.
  // On divide by zero the remainder ends up as the dividend magnitude, so applying
  // the dividend sign reproduces the raw dividend for HI.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  assign prod_fix = neg_res ? -acc : acc;
  assign quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi_o     <= '0;
      lo_o     <= '0;
      done_o   <= 1'b0;
      div0_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      div0_o <= 1'b0;
      case (state)
        IDLE: begin
          // a flush in the same cycle blocks acceptance of any request
          if (start_i && !flush_i) begin
            if (op_mul || op_div) begin
              state    <= CALC;
              cnt      <= '0;
              is_div   <= op_div;
              div_zero <= op_div && (src1_i == '0);
              neg_res  <= op_signed && (src0_i[WIDTH-1] ^ src1_i[WIDTH-1]);
              neg_rem  <= op_signed && src0_i[WIDTH-1];
              if (op_div) begin
                acc <= {{WIDTH{1'b0}}, mag0};
                opb <= mag1;
              end else begin
                acc <= {{WIDTH{1'b0}}, mag1};
                opb <= mag0;
              end
            end else if (op_i == OP_MTHI) begin
              hi_o <= src0_i;
            end else if (op_i == OP_MTLO) begin
              lo_o <= src0_i;
            end
          end
        end
        CALC: begin
          if (flush_i) begin
            state <= IDLE;
          end else begin
            if (is_div) begin
              acc <= {rem_new, acc[WIDTH-2:0], div_fit};
            end else begin
              acc <= {mul_sum, acc[WIDTH-1:1]};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) begin
              state <= FIX;
            end
          end
        end
        FIX: begin
          state <= IDLE;
          if (!flush_i) begin
            done_o <= 1'b1;
            div0_o <= div_zero;
            if (is_div) begin
              hi_o <= rem_fix;
              lo_o <= div_zero ? {WIDTH{1'b1}} : quo_fix;
            end else begin
              hi_o <= prod_fix[2*WIDTH-1:WIDTH];
              lo_o <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: scoreboard bench for alu_muldiv, one 32-bit and one 8-bit instance.
module tb_alu_muldiv;

  localparam int W  = 32;
  localparam int W8 = 8;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start, flush, busy, done, div0;
  logic [2:0]    op;
  logic [W-1:0]  a, b, hi, lo;
  logic          start8, flush8, busy8, done8, div08;
  logic [2:0]    op8;
  logic [W8-1:0] a8, b8, hi8, lo8;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .op_i(op), .src0_i(a), .src1_i(b),
    .flush_i(flush), .hi_o(hi), .lo_o(lo), .busy_o(busy), .done_o(done), .div0_o(div0)
  );

  alu_muldiv #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_i(start8), .op_i(op8), .src0_i(a8), .src1_i(b8),
    .flush_i(flush8), .hi_o(hi8), .lo_o(lo8), .busy_o(busy8), .done_o(done8), .div0_o(div08)
  );

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
  } exp_t;

  exp_t sb32[$];
  exp_t sb8[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   done_cnt32 = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] h, input logic [31:0] l, input logic d);
    exp_t r;
    r.hi = h;
    r.lo = l;
    r.div0 = d;
    return r;
  endfunction

  // reference model on native 64-bit arithmetic
  function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t r;
    longint p;
    longint unsigned pu;
    int sx, sy;
    r = '0;
    case (o)
      OP_MULT: begin
        p = longint'($signed(x)) * longint'($signed(y));
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      OP_MULTU: begin
        pu = {32'b0, x} * {32'b0, y};
        r.hi = pu[63:32];
        r.lo = pu[31:0];
      end
      OP_DIV: begin
        if (y == 0) r = mk(x, 32'hFFFF_FFFF, 1'b1);
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = mk(32'h0, 32'h8000_0000, 1'b0);
        else begin
          sx = x;
          sy = y;
          r.lo = sx / sy;
          r.hi = sx % sy;
        end
      end
      OP_DIVU: begin
        if (y == 0) r = mk(x, 32'hFFFF_FFFF, 1'b1);
        else begin
          r.lo = x / y;
          r.hi = x % y;
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin : mon32
    exp_t e;
    if (rst_n) begin
      if (done) begin
        done_cnt32++;
        if (sb32.size() == 0) chk("spurious_done32", 1, 0);
        else begin
          e = sb32.pop_front();
          chk("hi32", hi, e.hi);
          chk("lo32", lo, e.lo);
          chk("div0_32", div0, e.div0);
        end
      end else if (div0) chk("div0_without_done32", 1, 0);
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (rst_n) begin
      if (done8) begin
        if (sb8.size() == 0) chk("spurious_done8", 1, 0);
        else begin
          e = sb8.pop_front();
          chk("hi8", {24'b0, hi8}, e.hi);
          chk("lo8", {24'b0, lo8}, e.lo);
          chk("div0_8", div08, e.div0);
        end
      end else if (div08) chk("div0_without_done8", 1, 0);
    end
  end

  task automatic drive(input bit w8, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (w8) begin
      start8 = 1'b1; op8 = o; a8 = x[7:0]; b8 = y[7:0];
    end else begin
      start = 1'b1; op = o; a = x; b = y;
    end
    @(posedge clk); #1;
    start8 = 1'b0;
    start = 1'b0;
  endtask

  // called in cycle T+1; returns n = cycles since accept when done_o is seen
  task automatic wait_done(input bit w8, output int n, output bit busy_ok);
    n = 1;
    busy_ok = 1'b1;
    while (!(w8 ? done8 : done) && n < 200) begin
      if (!(w8 ? busy8 : busy)) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", (w8 ? done8 : done), 1);
    chk("busy_in_done_cycle", (w8 ? busy8 : busy), 0);
  endtask

  task automatic run32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input exp_t e);
    int n;
    bit bok;
    sb32.push_back(e);
    drive(1'b0, o, x, y);
    wait_done(1'b0, n, bok);
    chk("latency32", n, W + 2);
    chk("busy_while_calc32", bok, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    bit bok;
    logic [2:0] ro;
    logic [31:0] rx, ry;
    int d;

    rst_n = 1'b0;
    start = 0; flush = 0; op = 0; a = 0; b = 0;
    start8 = 0; flush8 = 0; op8 = 0; a8 = 0; b8 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_div0", div0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run32(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'hFFFF_FFFE, 32'h0000_0001, 1'b0));
    run32(OP_MULT, -32'sd7, 32'd3, mk(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0));
    run32(OP_MULT, 32'h8000_0000, 32'h8000_0000, mk(32'h4000_0000, 32'h0, 1'b0));
    run32(OP_DIV, -32'sd7, 32'd2, mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0));
    run32(OP_DIVU, 32'd100, 32'd7, mk(32'd2, 32'd14, 1'b0));
    run32(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h0, 32'h8000_0000, 1'b0));
    run32(OP_DIVU, 32'h1234, 32'h0, mk(32'h1234, 32'hFFFF_FFFF, 1'b1));
    run32(OP_DIV, -32'sd5, 32'h0, mk(32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1));

    for (int i = 0; i < 8; i++) begin
      ro = 3'($urandom_range(1, 4));
      rx = $urandom;
      ry = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
      if (i == 3) rx = -rx;
      run32(ro, rx, ry, model(ro, rx, ry));
    end

    // MTHI then MTLO on consecutive edges
    start = 1'b1; op = OP_MTHI; a = 32'hAA;
    @(posedge clk); #1;
    chk("mthi_hi", hi, 32'hAA);
    chk("mthi_busy", busy, 0);
    op = OP_MTLO; a = 32'h55;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h55);
    chk("mtlo_hi_kept", hi, 32'hAA);
    chk("mtlo_busy", busy, 0);
    chk("mt_no_done", done, 0);

    // flush in IDLE blocks a same-edge start
    start = 1'b1; flush = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("idle_flush_not_accepted", busy, 0);

    // flush mid-operation: sampled at edge T+10
    d = done_cnt32;
    drive(1'b0, OP_MULT, 32'd3, 32'd5);
    repeat (8) @(posedge clk);
    #1;
    chk("busy_before_flush", busy, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_hi", hi, 32'hAA);
    chk("flush_lo", lo, 32'h55);
    repeat (W + 5) @(posedge clk);
    #1;
    chk("flush_no_done", done_cnt32, d);

    // start while busy is ignored, HI/LO untouched during CALC
    d = done_cnt32;
    sb32.push_back(mk(32'd2, 32'd14, 1'b0));
    drive(1'b0, OP_DIVU, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    drive(1'b0, OP_MTHI, 32'hDEAD, 32'h0);
    chk("busy_mthi_ignored", hi, 32'hAA);
    drive(1'b0, OP_MULT, 32'd9, 32'd9);
    chk("calc_lo_stable", lo, 32'h55);
    wait_done(1'b0, n, bok);
    repeat (W + 5) @(posedge clk);
    #1;
    chk("busy_start_ignored", done_cnt32, d + 1);

    // 8-bit instance: latency and back-to-back issue in the done cycle
    sb8.push_back(mk(32'h00, 32'h80, 1'b0));
    drive(1'b1, OP_MULT, 32'h80, 32'hFF);
    wait_done(1'b1, n, bok);
    chk("latency8_mult", n, W8 + 2);
    chk("busy_while_calc8", bok, 1);
    sb8.push_back(mk(32'd2, 32'd66, 1'b0));
    drive(1'b1, OP_DIVU, 32'd200, 32'd3);
    wait_done(1'b1, n, bok);
    chk("latency8_b2b", n, W8 + 2);

    repeat (3) @(posedge clk);
    #1;
    chk("sb32_empty", sb32.size(), 0);
    chk("sb8_empty", sb8.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised iterative multiply/divide unit beside the EX-stage combinational ALU of the pipelined CPU.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and owns the architectural HI/LO registers, also written by MTHI/MTLO.
- Exposes busy/done so the hazard unit stalls the pipeline while an operation is in flight.
- flush_i lets exception/branch logic abort an operation in progress.

Parameters:
- WIDTH, 32, operand/HI/LO width in bits (>=4, even).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- start_i  in  1  request; accepted only in IDLE
- op_i  in  3  000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 NOP
- src0_i  in  WIDTH  rs value (multiplicand/dividend; MTHI/MTLO data)
- src1_i  in  WIDTH  rt value (multiplier/divisor)
- flush_i  in  1  abort in-flight operation
- hi_o  out  WIDTH  HI register
- lo_o  out  WIDTH  LO register
- busy_o  out  1  operation in flight
- done_o  out  1  one-cycle pulse; HI/LO just updated by mul/div
- div0_o  out  1  valid with done_o; last op was DIV/DIVU with src1=0

Behaviour:
- Reset (rst_n=0 at edge): hi_o=lo_o=0, busy_o=done_o=div0_o=0, state IDLE, counter=0. Reset mid-operation discards everything.
- States: IDLE, CALC, FIX.
- IDLE:
  - start_i with MULT/MULTU/DIV/DIVU at edge T: latch operands and signedness; signed ops convert operands to magnitudes; record result-sign flags; counter=0; go CALC.
  - start_i with MTHI/MTLO: write hi_o/lo_o at edge T; remain IDLE; no busy, no done.
  - NOP: ignored.
- CALC: one iteration per cycle, WIDTH cycles (T+1..T+WIDTH), counter 0..WIDTH-1.
  - Multiply: shift-add over 2*WIDTH accumulator, unsigned magnitudes.
  - Divide: restoring, one quotient bit per cycle, unsigned magnitudes.
  - After the last iteration go FIX.
- FIX: one cycle (T+WIDTH+1).
  - Apply signs: product negated if operand signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
  - Write hi_o = product[2W-1:W] or remainder; lo_o = product[W-1:0] or quotient.
  - Go IDLE; done_o=1 in cycle T+WIDTH+2.
- busy_o=1 in cycles T+1..T+WIDTH+1; 0 in the done cycle. Total latency from accept to visible HI/LO: WIDTH+2 cycles.
- start_i is accepted in the done cycle (back-to-back).
- start_i while busy_o=1 is ignored; no queuing.
- HI/LO change only at FIX or on MTHI/MTLO, never during CALC.
- Divide by zero: lo_o = all ones, hi_o = src0_i (raw, signed or unsigned); div0_o=1 with done_o; latency unchanged.
- Signed overflow (DIV of MIN by -1): lo_o=MIN, hi_o=0, no flag.
- flush_i=1 in IDLE: no effect; a same-edge start_i is still not accepted.
- flush_i=1 in CALC/FIX: return to IDLE next edge, busy_o=0, HI/LO unchanged, no done_o. flush has priority over FIX write-back.
- done_o/div0_o are single-cycle registered pulses; div0_o=0 whenever done_o=0.

Test Plan:
- WIDTH=32. Reset, then MULTU 0xFFFFFFFF × 0xFFFFFFFF at T → busy cycles T+1..T+33; done at T+34; hi=0xFFFFFFFE, lo=0x00000001.
- MULT -7 × 3 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- DIV -7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 → lo=14, hi=2. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0, div0_o=0.
- DIVU 0x1234 / 0 → lo=0xFFFFFFFF, hi=0x1234, div0_o=1 with done_o. DIV -5 / 0 → hi=0xFFFFFFFB.
- MTHI 0xAA then MTLO 0x55 in consecutive cycles → hi=0xAA, lo=0x55 after each edge, busy_o never 1. start MULT then flush_i at T+10 → busy_o=0 at T+11, hi/lo still 0xAA/0x55, no done_o. start_i during busy ignored.
- WIDTH=8 build: MULT 0x80 × 0xFF → hi=0x00, lo=0x80; done at T+10. Back-to-back DIVU 200/3 issued in the done cycle → lo=66, hi=2.
